// File: rtl/pcoeff_result_collector_pkg.sv
// Shared widths and entry layout for the pcoeff result collector.
// PCOEFF_SANITY_CHECK_EN adds a per-entry sanity flag bit.
package pcoeff_result_collector_pkg;

  localparam int DEF_COUNT_W = 35;
  localparam int SUM_EXTRA_W = 35;

`ifdef PCOEFF_SANITY_CHECK_EN
  localparam int FLAG_W  = 2;
  localparam int SAN_LSB = 1;
`else
  localparam int FLAG_W  = 1;
`endif
  localparam int ECC_LSB   = 0;
  localparam int COUNT_LSB = FLAG_W;

  // Entry layout from LSB: flags, count, sum, seq.
  function automatic int sum_lsb(input int cw);
    return FLAG_W + cw;
  endfunction

  function automatic int seq_lsb(input int cw);
    return FLAG_W + cw + cw + SUM_EXTRA_W;
  endfunction

  function automatic int entry_w(input int cw, input int sw);
    return seq_lsb(cw) + sw;
  endfunction

endpackage

// File: rtl/pcoeff_result_collector_fifo.sv
// First-word fall-through FIFO with registered storage.
// A push into a full FIFO is accepted only alongside a pop.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          push_ok, pop_ok;

  always_comb begin
    empty   = (occ_q == '0);
    full    = (occ_q == (AW+1)'(DEPTH));
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + AW'(1) : rptr_q;
    occ_d   = occ_q;
    if (push_ok && !pop_ok) occ_d = occ_q + (AW+1)'(1);
    if (!push_ok && pop_ok) occ_d = occ_q - (AW+1)'(1);
    rdata     = empty ? '0 : mem_q[rptr_q];
    occupancy = occ_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/pcoeff_result_collector.sv
// Tags batch results with a sequence number and ECC flag, buffers them,
// and issues batch credits upstream. PCOEFF_SANITY_CHECK_EN adds outSanityErr.
module pcoeff_result_collector
  import pcoeff_result_collector_pkg::*;
#(
  parameter int PCOEFF_COUNT_BITWIDTH = DEF_COUNT_W,
  parameter int DEPTH                 = 16,
  parameter int SEQ_WIDTH             = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   batchIssued,
  output logic                                   canIssueBatch,
  input  logic                                   resultsValid,
  input  logic [PCOEFF_COUNT_BITWIDTH+35-1:0]    pcoeffSum,
  input  logic [PCOEFF_COUNT_BITWIDTH-1:0]       pcoeffCount,
  input  logic                                   eccStatus,
  output logic                                   outValid,
  input  logic                                   outReady,
  output logic [SEQ_WIDTH-1:0]                   outSeq,
  output logic [PCOEFF_COUNT_BITWIDTH+35-1:0]    outSum,
  output logic [PCOEFF_COUNT_BITWIDTH-1:0]       outCount,
  output logic                                   outEcc,
  output logic [$clog2(DEPTH):0]                 occupancy,
  output logic                                   errOverflow,
  output logic                                   errUnexpected
`ifdef PCOEFF_SANITY_CHECK_EN
  ,
  output logic                                   outSanityErr
`endif
);

  localparam int CW      = PCOEFF_COUNT_BITWIDTH;
  localparam int SW      = CW + SUM_EXTRA_W;
  localparam int OW      = $clog2(DEPTH) + 1;
  localparam int EW      = entry_w(CW, SEQ_WIDTH);
  localparam int SUM_LSB = sum_lsb(CW);
  localparam int SEQ_LSB = seq_lsb(CW);

  logic [OW-1:0]        outstanding_q, outstanding_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic                 batch_ecc_q, batch_ecc_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 err_unexp_q, err_unexp_d;

  logic [EW-1:0] wdata, rdata;
  logic          full, empty, pop, ecc_now;
  logic [OW-1:0] fifo_occ;
  logic [OW:0]   credit_sum;

`ifdef PCOEFF_SANITY_CHECK_EN
  logic          sanity;
  logic [SW-1:0] count_ext;

  always_comb begin
    count_ext = {{SUM_EXTRA_W{1'b0}}, pcoeffCount};
    sanity    = ((pcoeffCount == '0) && (pcoeffSum != '0))
             || (pcoeffSum < count_ext)
             || (pcoeffSum > (count_ext << SUM_EXTRA_W));
  end
`endif

  always_comb begin
    pop     = !empty && outReady;
    ecc_now = batch_ecc_q | eccStatus;
`ifdef PCOEFF_SANITY_CHECK_EN
    wdata = {seq_q, pcoeffSum, pcoeffCount, sanity, ecc_now | sanity};
`else
    wdata = {seq_q, pcoeffSum, pcoeffCount, ecc_now};
`endif

    outstanding_d = outstanding_q;
    unique case ({batchIssued, resultsValid})
      2'b10: if (outstanding_q != '1) outstanding_d = outstanding_q + OW'(1);
      2'b01: if (outstanding_q != '0) outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    seq_d       = resultsValid ? seq_q + SEQ_WIDTH'(1) : seq_q;
    batch_ecc_d = resultsValid ? 1'b0 : ecc_now;
    err_ovf_d   = err_ovf_q | (resultsValid && full && !pop);
    err_unexp_d = err_unexp_q | (resultsValid && (outstanding_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      seq_q         <= '0;
      batch_ecc_q   <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      seq_q         <= seq_d;
      batch_ecc_q   <= batch_ecc_d;
      err_ovf_q     <= err_ovf_d;
      err_unexp_q   <= err_unexp_d;
    end
  end

  result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resultsValid),
    .pop       (pop),
    .wdata     (wdata),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .occupancy (fifo_occ)
  );

  always_comb begin
    credit_sum    = {1'b0, outstanding_q} + {1'b0, fifo_occ};
    canIssueBatch = credit_sum < (OW+1)'(DEPTH);
    outValid      = !empty;
    occupancy     = fifo_occ;
    outSeq        = rdata[SEQ_LSB +: SEQ_WIDTH];
    outSum        = rdata[SUM_LSB +: SW];
    outCount      = rdata[COUNT_LSB +: CW];
    outEcc        = rdata[ECC_LSB];
    errOverflow   = err_ovf_q;
    errUnexpected = err_unexp_q;
  end

`ifdef PCOEFF_SANITY_CHECK_EN
  assign outSanityErr = rdata[SAN_LSB];
`endif

endmodule

// File: tb/tb_pcoeff_result_collector.sv
// Scoreboard bench for pcoeff_result_collector with a queue-based model.
// Define PCOEFF_SANITY_CHECK_EN to exercise the sanity flag.
module tb_pcoeff_result_collector;

  localparam int D  = 16;
  localparam int CW = 35;
  localparam int SW = 70;
  localparam int QW = 16;

  logic          clk = 0;
  logic          rst = 1;
  logic          batchIssued = 0, resultsValid = 0, eccStatus = 0;
  logic          outReady = 0;
  logic [SW-1:0] pcoeffSum = '0;
  logic [CW-1:0] pcoeffCount = '0;
  logic          canIssueBatch, outValid, outEcc;
  logic          errOverflow, errUnexpected;
  logic [QW-1:0] outSeq;
  logic [SW-1:0] outSum;
  logic [CW-1:0] outCount;
  logic [4:0]    occupancy;
`ifdef PCOEFF_SANITY_CHECK_EN
  logic          outSanityErr;
`endif

  pcoeff_result_collector #(
    .PCOEFF_COUNT_BITWIDTH (CW),
    .DEPTH                 (D),
    .SEQ_WIDTH             (QW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .batchIssued   (batchIssued),
    .canIssueBatch (canIssueBatch),
    .resultsValid  (resultsValid),
    .pcoeffSum     (pcoeffSum),
    .pcoeffCount   (pcoeffCount),
    .eccStatus     (eccStatus),
    .outValid      (outValid),
    .outReady      (outReady),
    .outSeq        (outSeq),
    .outSum        (outSum),
    .outCount      (outCount),
    .outEcc        (outEcc),
    .occupancy     (occupancy),
    .errOverflow   (errOverflow),
    .errUnexpected (errUnexpected)
`ifdef PCOEFF_SANITY_CHECK_EN
    ,
    .outSanityErr  (outSanityErr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: entries held in a queue, counters as plain integers.
  typedef struct {
    logic [QW-1:0] seq;
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
    bit            ecc;
    bit            san;
  } ent_t;

  ent_t sbq[$];
  int   m_out, m_occ, m_seq;
  bit   m_becc, m_eovf, m_eunx;

  function automatic bit insane(input logic [SW-1:0] s, input logic [CW-1:0] c);
    logic [SW-1:0] ce;
    ce = SW'(c);
    return (c == 0 && s != 0) || (s < ce) || (s > (ce << 35));
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      sbq.delete();
      m_out = 0; m_occ = 0; m_seq = 0;
      m_becc = 0; m_eovf = 0; m_eunx = 0;
    end else begin
      bit   pop_m, acc;
      ent_t e;
      pop_m = (m_occ > 0) && outReady;
      acc = 0;
      if (resultsValid) begin
        e.seq = QW'(m_seq);
        e.sum = pcoeffSum;
        e.cnt = pcoeffCount;
        e.ecc = m_becc | eccStatus;
        e.san = 0;
`ifdef PCOEFF_SANITY_CHECK_EN
        e.san = insane(pcoeffSum, pcoeffCount);
        e.ecc = e.ecc | e.san;
`endif
        if (m_out == 0) m_eunx = 1;
        if (m_occ < D || pop_m) begin
          sbq.push_back(e);
          acc = 1;
        end else begin
          m_eovf = 1;
        end
        m_seq = (m_seq + 1) % (1 << QW);
        m_becc = 0;
      end else begin
        m_becc = m_becc | eccStatus;
      end
      if (batchIssued && !resultsValid) m_out++;
      else if (!batchIssued && resultsValid && m_out > 0) m_out--;
      m_occ = m_occ + int'(acc) - int'(pop_m);
    end
  end

  // Monitor: compares state each cycle and pops expected entries on handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("occupancy", occupancy, m_occ);
      chk("outValid", outValid, m_occ > 0);
      chk("canIssueBatch", canIssueBatch, (m_out + m_occ) < D);
      chk("errOverflow", errOverflow, m_eovf);
      chk("errUnexpected", errUnexpected, m_eunx);
      if (outValid && outReady) begin
        if (sbq.size() == 0) begin
          chk("unexpected_entry", 1'b1, 1'b0);
        end else begin
          ent_t e;
          e = sbq.pop_front();
          chk("outSeq", outSeq, e.seq);
          chk("outSum", outSum, e.sum);
          chk("outCount", outCount, e.cnt);
          chk("outEcc", outEcc, e.ecc);
`ifdef PCOEFF_SANITY_CHECK_EN
          chk("outSanityErr", outSanityErr, e.san);
`endif
        end
      end
    end
  end

  task automatic step(input bit iss, input bit rv, input bit ecc,
                      input bit rdy, input logic [SW-1:0] s,
                      input logic [CW-1:0] c);
    batchIssued  = iss;
    resultsValid = rv;
    eccStatus    = ecc;
    outReady     = rdy;
    pcoeffSum    = s;
    pcoeffCount  = c;
    @(posedge clk);
    #1;
    batchIssued  = 0;
    resultsValid = 0;
    eccStatus    = 0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_outValid", outValid, 1'b0);
    chk("rst_occupancy", occupancy, 5'd0);
    chk("rst_canIssue", canIssueBatch, 1'b1);
    chk("rst_errOverflow", errOverflow, 1'b0);
    chk("rst_errUnexpected", errUnexpected, 1'b0);
    chk("rst_outSeq", outSeq, '0);
    chk("rst_outSum", outSum, '0);
    chk("rst_outCount", outCount, '0);
    chk("rst_outEcc", outEcc, 1'b0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int n;
    logic [SW-1:0] big;
    @(posedge clk);
    #1;
    do_reset();

    // Three in-order results
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, '0, '0);
    big = SW'(1) << 35;
    step(0, 1, 0, 1, SW'(5), CW'(3));
    idle(1, 1);
    step(0, 1, 0, 1, '0, '0);
    step(0, 1, 0, 1, big, CW'(1));
    idle(3, 1);
    chk("outstanding_zero", canIssueBatch, 1'b1);

    // Fill the FIFO, then overflow with no pop
    n = 0;
    while (canIssueBatch && n < 40) begin
      step(1, 0, 0, 0, '0, '0);
      n++;
    end
    chk("issued_until_no_credit", n, 16);
    for (int i = 0; i < D; i++) step(0, 1, 0, 0, SW'(i + 1), CW'(1));
    chk("full_occupancy", occupancy, 5'd16);
    chk("full_no_overflow", errOverflow, 1'b0);
    step(1, 0, 0, 0, '0, '0);
    step(0, 1, 0, 0, SW'(99), CW'(1));
    chk("overflow_sticky", errOverflow, 1'b1);
    chk("overflow_dropped", occupancy, 5'd16);
    idle(20, 1);
    chk("drained_credit", canIssueBatch, 1'b1);

    // Full FIFO with same-cycle pop accepts the write
    do_reset();
    for (int i = 0; i < D; i++) step(1, 0, 0, 0, '0, '0);
    for (int i = 0; i < D; i++) step(0, 1, 0, 0, SW'(2 * i + 2), CW'(2));
    step(1, 0, 0, 0, '0, '0);
    step(0, 1, 0, 1, SW'(77), CW'(7));
    chk("pop_push_occupancy", occupancy, 5'd16);
    chk("pop_push_no_overflow", errOverflow, 1'b0);
    idle(20, 1);

    // ECC attribution across three batches
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, '0, '0);
    step(0, 0, 1, 1, '0, '0);
    step(0, 1, 0, 1, SW'(4), CW'(2));
    step(0, 1, 1, 1, SW'(6), CW'(3));
    step(0, 1, 0, 1, SW'(8), CW'(4));
    idle(3, 1);

    // Result with nothing outstanding
    step(0, 1, 0, 1, SW'(3), CW'(1));
    chk("unexpected_sticky", errUnexpected, 1'b1);
    idle(2, 1);

`ifdef PCOEFF_SANITY_CHECK_EN
    do_reset();
    step(1, 0, 0, 1, '0, '0);
    step(1, 0, 0, 1, '0, '0);
    step(0, 1, 0, 1, SW'(2), CW'(3));
    chk("sanity_flag_set", outSanityErr, 1'b1);
    chk("sanity_ecc_set", outEcc, 1'b1);
    idle(1, 1);
    step(0, 1, 0, 1, SW'(3), CW'(3));
    chk("sanity_flag_clear", outSanityErr, 1'b0);
    idle(2, 1);
`endif

    // Randomised traffic, then reset mid-stream
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit iss, rv;
      logic [CW-1:0] c;
      logic [SW-1:0] s;
      iss = canIssueBatch && ($urandom_range(0, 2) != 0);
      rv  = (m_out > 0) && ($urandom_range(0, 2) == 0);
      c   = CW'($urandom_range(0, 1000));
      if ($urandom_range(0, 3) == 0)
        s = {$urandom, $urandom, $urandom};
      else
        s = SW'(c) * SW'($urandom_range(1, 60));
      step(iss, rv, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, s, c);
      if (i == 400) do_reset();
    end
    idle(24, 1);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcoeff_result_collector.md
Name: pcoeff_result_collector

Overview:
- Sits directly downstream of the aggregating pipeline and consumes its per-batch result pulse (pcoeffSum, pcoeffCount, eccStatus).
- Tags each result with a batch sequence number and merges ECC events seen during the batch into a per-result flag.
- Buffers results in a small FIFO and presents them on a valid/ready stream to the host-side result writer.
- Issues batch credits upstream so the FIFO can never overflow under correct use.

Parameters:
- PCOEFF_COUNT_BITWIDTH, 35, width of pcoeffCount; pcoeffSum width is PCOEFF_COUNT_BITWIDTH+35.
- DEPTH, 16, result FIFO entries; power of two, 2..64.
- SEQ_WIDTH, 16, batch sequence tag width; wraps modulo 2^SEQ_WIDTH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- batchIssued  in  1  one-cycle pulse when the feeder commits a batch to the pipeline.
- canIssueBatch  out  1  credit available; the feeder may pulse batchIssued only while this is high.
- resultsValid  in  1  one-cycle pulse: pcoeffSum and pcoeffCount hold the final batch values.
- pcoeffSum  in  PCOEFF_COUNT_BITWIDTH+35  batch pcoeff sum.
- pcoeffCount  in  PCOEFF_COUNT_BITWIDTH  batch bot count.
- eccStatus  in  1  per-cycle ECC/sanity error from the pipeline.
- outValid  out  1  output entry available.
- outReady  in  1  consumer accepts the entry when outValid && outReady.
- outSeq  out  SEQ_WIDTH  batch sequence number.
- outSum  out  PCOEFF_COUNT_BITWIDTH+35  stored sum.
- outCount  out  PCOEFF_COUNT_BITWIDTH  stored count.
- outEcc  out  1  eccStatus was seen at least once during this batch.
- occupancy  out  $clog2(DEPTH)+1  current FIFO fill level.
- errOverflow  out  1  sticky: a result arrived while the FIFO was full and had no pop.
- errUnexpected  out  1  sticky: resultsValid arrived with outstanding==0.

Behaviour:
- Reset (async, immediate): all outputs 0 except canIssueBatch=1. outstanding=0, seq counter=0, FIFO empty, batchEcc=0, sticky errors=0.
- outstanding counter (width $clog2(DEPTH)+1):
  - +1 on batchIssued; -1 on resultsValid when nonzero.
  - Both in the same cycle: unchanged.
  - resultsValid with outstanding==0: counter stays 0 and errUnexpected sets; the result is still stored if space exists.
- canIssueBatch = (outstanding + occupancy) < DEPTH, driven combinationally from registers.
  - A batchIssued pulse while canIssueBatch==0 is still counted; the resulting overflow is reported via errOverflow.
- batchEcc register:
  - Each cycle without resultsValid: batchEcc <= batchEcc | eccStatus.
  - On resultsValid: the captured outEcc value is batchEcc | eccStatus, and batchEcc then clears to 0. Same-cycle ECC is attributed to the closing batch.
- Capture: on resultsValid the entry {seq, pcoeffSum, pcoeffCount, ecc} is written at that clock edge. seq counter increments and wraps from 2^SEQ_WIDTH-1 to 0.
- Write acceptance: write succeeds if FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise the entry is dropped, seq still increments, and errOverflow sets.
- Latency: resultsValid sampled at edge N; outValid=1 after edge N (first-word fall-through from registered storage). Output fields are stable while outValid && !outReady.
- Pop: on outValid && outReady. Simultaneous push and pop leaves occupancy unchanged. Pop from empty is impossible (outValid=0).
- Sticky errors clear only on rst.

Optional Feature:
- Macro: PCOEFF_SANITY_CHECK_EN.
- Defined:
  - Adds output outSanityErr (1 bit), stored per entry.
  - Set when pcoeffCount==0 && pcoeffSum!=0, or pcoeffSum < pcoeffCount (every pcoeff is at least 1), or pcoeffSum > (pcoeffCount << 35).
  - The check is computed combinationally at capture and also ORed into outEcc.
- Not defined: port absent, no comparators, outEcc per the base rule only.

Decomposition:
- pipelineGlobals header: PCOEFF_COUNT_BITWIDTH, derived sum width, entry field offsets, and total entry width.
- Sub-module result_fifo: parameterised width/depth, first-word fall-through, push/pop/full/empty/occupancy.
- The collector holds the credit counter, seq counter, batchEcc, sanity logic and error flags.

Test Plan:
- Reset, then issue 3 batches; results (sum=5,count=3), (sum=0,count=0), (sum=2^35,count=1) with outReady=1 → outSeq 0,1,2 in order with matching fields, one cycle after each resultsValid; outstanding returns to 0.
- DEPTH=16, outReady=0, issue batches until canIssueBatch falls → exactly 16 issued. Deliver 16 results → occupancy=16, errOverflow=0. Raise outReady → 16 pops, canIssueBatch=1.
- Force a 17th result while full, with no pop → errOverflow=1 and the entry is dropped. In a separate run, pop on the same cycle as the write → entry stored, occupancy stays 16.
- eccStatus pulse mid-batch 0, another coincident with resultsValid of batch 1 → both entries outEcc=1; batch 2 has outEcc=0.
- resultsValid with no batchIssued → errUnexpected=1, entry stored. Assert rst mid-stream → all outputs reset immediately and FIFO empty.
- With PCOEFF_SANITY_CHECK_EN: (sum=2,count=3) → outSanityErr=1 and outEcc=1; (sum=3,count=3) → outSanityErr=0.
